// File: rtl/apb_csb_pkg.sv
// -----------------------------------------------------------------------------
// apb_csb_pkg
// Shared types and helpers for the APB -> CSB bridge.
//   state_t      : bridge FSM states
//   DEF_ERR_DATA : default read data returned on an errored read
//   win_match()  : address-window compare over a bit range [lsb, msb_excl)
// -----------------------------------------------------------------------------
package apb_csb_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_REQ,
      ST_WAIT_RD,
      ST_WAIT_WR,
      ST_RESP
   } state_t;

   localparam logic [31:0] DEF_ERR_DATA = 32'hDEAD_BEEF;

   // True when addr and base agree on every bit in [lsb, msb_excl).
   // An empty range (no window bits above the CSB space) always matches.
   function automatic logic win_match(input logic [63:0] addr,
                                      input logic [63:0] base,
                                      input int          lsb,
                                      input int          msb_excl);
      logic m;
      m = 1'b1;
      for (int i = 0; i < 64; i++) begin
         if (i >= lsb && i < msb_excl && (addr[i] != base[i])) m = 1'b0;
      end
      return m;
   endfunction

endpackage

// File: rtl/csb_resp_timer.sv
// -----------------------------------------------------------------------------
// csb_resp_timer
// Loadable up-counter that flags the last permitted waiting cycle.
//   clk, reset : clock, async active-high reset
//   i_load     : restart the count at 0 (wins over i_run)
//   i_run      : advance the count this cycle
//   o_expire   : combinational, high while running with count == TIMEOUT_CYC-1
// TIMEOUT_CYC = 0 disables the timer (o_expire never asserts).
// -----------------------------------------------------------------------------
module csb_resp_timer #(
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic clk,
   input  logic reset,
   input  logic i_load,
   input  logic i_run,
   output logic o_expire
);

   localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam int LAST = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;

   logic [CW-1:0] r_cnt;
   logic          w_term;

   assign w_term   = (r_cnt == CW'(LAST));
   assign o_expire = (TIMEOUT_CYC != 0) && i_run && w_term;

   // Count parks at its terminal value so a late run never wraps.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                  r_cnt <= '0;
      else if (i_load)            r_cnt <= '0;
      else if (i_run && !w_term)  r_cnt <= r_cnt + 1'b1;
   end

endmodule

// File: rtl/apb_csb_bridge_v2.sv
// -----------------------------------------------------------------------------
// apb_csb_bridge_v2
// APB slave -> NVDLA CSB master. One CSB request per APB access, with an
// address-window check, optional non-posted writes, a response timeout,
// orphan-response discard and a saturating error counter.
//   clk, reset             : single clock, async active-high reset
//   psel/penable/pwrite/
//   paddr/pwdata           : APB request
//   prdata/pready/pslverr  : APB response (registered, high for the RESP cycle)
//   csb2nvdla_*            : CSB request (registered, held until ready)
//   nvdla2csb_*            : CSB read data / write completion
//   err_count              : window errors + timeouts, saturating
// Access cycle counted as cycle 1: window error -> pready in cycle 2,
// posted write with immediate ready -> cycle 3, read -> 3 + response delay.
// -----------------------------------------------------------------------------
module apb_csb_bridge_v2
   import apb_csb_pkg::*;
#(
   parameter int                 ADDR_W      = 32,
   parameter int                 CSB_ADDR_W  = 16,
   parameter int                 DATA_W      = 32,
   parameter logic [ADDR_W-1:0]  WIN_BASE    = '0,
   parameter bit                 NPOSTED_WR  = 1'b1,
   parameter int                 TIMEOUT_CYC = 1024,
   parameter logic [DATA_W-1:0]  ERR_DATA    = DATA_W'(DEF_ERR_DATA)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  psel,
   input  logic                  penable,
   input  logic                  pwrite,
   input  logic [ADDR_W-1:0]     paddr,
   input  logic [DATA_W-1:0]     pwdata,
   output logic [DATA_W-1:0]     prdata,
   output logic                  pready,
   output logic                  pslverr,
   output logic                  csb2nvdla_valid,
   input  logic                  csb2nvdla_ready,
   output logic [CSB_ADDR_W-1:0] csb2nvdla_addr,
   output logic [DATA_W-1:0]     csb2nvdla_wdat,
   output logic                  csb2nvdla_write,
   output logic                  csb2nvdla_nposted,
   input  logic                  nvdla2csb_valid,
   input  logic [DATA_W-1:0]     nvdla2csb_data,
   input  logic                  nvdla2csb_wr_complete,
   output logic [15:0]           err_count
);

   state_t                r_state;
   logic [DATA_W-1:0]     r_prdata;
   logic                  r_pready;
   logic                  r_pslverr;
   logic                  r_csb_valid;
   logic [CSB_ADDR_W-1:0] r_csb_addr;
   logic [DATA_W-1:0]     r_csb_wdat;
   logic                  r_csb_write;
   logic                  r_csb_nposted;
   logic                  r_orphan;
   logic [15:0]           r_err_cnt;

   logic w_access, w_in_win, w_win_err, w_accept, w_tmo;
   logic w_tmr_load, w_tmr_run, w_expire;

   // A pending orphan blocks new accesses until it is drained or aged out.
   assign w_access  = (r_state == ST_IDLE) && psel && penable && !r_orphan;
   assign w_in_win  = win_match(64'(paddr), 64'(WIN_BASE), CSB_ADDR_W + 2, ADDR_W);
   assign w_win_err = w_access && !w_in_win;
   assign w_accept  = (r_state == ST_REQ) && csb2nvdla_ready;
   // A response arriving on the expiry cycle still wins over the timeout.
   assign w_tmo     = w_expire &&
                      (((r_state == ST_WAIT_RD) && !nvdla2csb_valid) ||
                       ((r_state == ST_WAIT_WR) && !nvdla2csb_wr_complete));

   // One timer serves both the response wait and the orphan hold window;
   // it restarts on CSB accept and again on timeout.
   assign w_tmr_load = w_accept || w_tmo;
   assign w_tmr_run  = (r_state == ST_WAIT_RD) || (r_state == ST_WAIT_WR) || r_orphan;

   csb_resp_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
      .clk      (clk),
      .reset    (reset),
      .i_load   (w_tmr_load),
      .i_run    (w_tmr_run),
      .o_expire (w_expire)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state       <= ST_IDLE;
         r_prdata      <= '0;
         r_pready      <= 1'b0;
         r_pslverr     <= 1'b0;
         r_csb_valid   <= 1'b0;
         r_csb_addr    <= '0;
         r_csb_wdat    <= '0;
         r_csb_write   <= 1'b0;
         r_csb_nposted <= 1'b0;
         r_orphan      <= 1'b0;
      end else begin
         // APB response lives for the RESP cycle only.
         r_pready  <= 1'b0;
         r_pslverr <= 1'b0;
         r_prdata  <= '0;

         if (r_orphan && (nvdla2csb_valid || nvdla2csb_wr_complete || w_expire))
            r_orphan <= 1'b0;

         case (r_state)
            ST_IDLE: begin
               if (w_win_err) begin
                  r_state   <= ST_RESP;
                  r_pready  <= 1'b1;
                  r_pslverr <= 1'b1;
                  r_prdata  <= pwrite ? '0 : ERR_DATA;
               end else if (w_access) begin
                  r_state       <= ST_REQ;
                  r_csb_valid   <= 1'b1;
                  r_csb_addr    <= paddr[CSB_ADDR_W+1:2];
                  r_csb_wdat    <= pwdata;
                  r_csb_write   <= pwrite;
                  r_csb_nposted <= pwrite & NPOSTED_WR;
               end
            end
            ST_REQ: begin
               if (csb2nvdla_ready) begin
                  r_csb_valid <= 1'b0;
                  if (!r_csb_write) begin
                     // Read data may come back in the handshake cycle itself.
                     if (nvdla2csb_valid) begin
                        r_state  <= ST_RESP;
                        r_pready <= 1'b1;
                        r_prdata <= nvdla2csb_data;
                     end else begin
                        r_state <= ST_WAIT_RD;
                     end
                  end else if (NPOSTED_WR) begin
                     r_state <= ST_WAIT_WR;
                  end else begin
                     r_state  <= ST_RESP;
                     r_pready <= 1'b1;
                  end
               end
            end
            ST_WAIT_RD: begin
               if (nvdla2csb_valid) begin
                  r_state  <= ST_RESP;
                  r_pready <= 1'b1;
                  r_prdata <= nvdla2csb_data;
               end else if (w_tmo) begin
                  r_state   <= ST_RESP;
                  r_pready  <= 1'b1;
                  r_pslverr <= 1'b1;
                  r_prdata  <= ERR_DATA;
                  r_orphan  <= 1'b1;
               end
            end
            ST_WAIT_WR: begin
               if (nvdla2csb_wr_complete) begin
                  r_state  <= ST_RESP;
                  r_pready <= 1'b1;
               end else if (w_tmo) begin
                  r_state   <= ST_RESP;
                  r_pready  <= 1'b1;
                  r_pslverr <= 1'b1;
                  r_orphan  <= 1'b1;
               end
            end
            ST_RESP: r_state <= ST_IDLE;
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)                                  r_err_cnt <= '0;
      else if ((w_win_err || w_tmo) && (r_err_cnt != 16'hFFFF))
                                                  r_err_cnt <= r_err_cnt + 16'd1;
   end

   assign prdata            = r_prdata;
   assign pready            = r_pready;
   assign pslverr           = r_pslverr;
   assign csb2nvdla_valid   = r_csb_valid;
   assign csb2nvdla_addr    = r_csb_addr;
   assign csb2nvdla_wdat    = r_csb_wdat;
   assign csb2nvdla_write   = r_csb_write;
   assign csb2nvdla_nposted = r_csb_nposted;
   assign err_count         = r_err_cnt;

endmodule

// File: tb/tb_apb_csb_bridge_v2.sv
// -----------------------------------------------------------------------------
// tb_apb_csb_bridge_v2
// Scoreboard bench: the APB driver pushes the expected response (data, error,
// latency from access cycle) and a negedge monitor pops/compares on pready.
// A second instance with posted writes shares all inputs.
// -----------------------------------------------------------------------------
module tb_apb_csb_bridge_v2;

   logic        clk = 1'b0;
   logic        reset;
   logic        psel, penable, pwrite;
   logic [31:0] paddr, pwdata;
   logic [31:0] prdata;
   logic        pready, pslverr;
   logic        csb_valid, csb_ready, csb_write, csb_nposted;
   logic [15:0] csb_addr;
   logic [31:0] csb_wdat;
   logic        nv_valid, wr_cmp;
   logic [31:0] nv_data;
   logic [15:0] err_count;

   // posted-write instance outputs
   logic [31:0] p_prdata, p_wdat;
   logic        p_pready, p_pslverr, p_valid, p_write, p_nposted;
   logic [15:0] p_addr, p_err_count;

   apb_csb_bridge_v2 #(.NPOSTED_WR(1'b1), .TIMEOUT_CYC(16)) u_dut (
      .clk(clk), .reset(reset), .psel(psel), .penable(penable), .pwrite(pwrite),
      .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready),
      .pslverr(pslverr), .csb2nvdla_valid(csb_valid), .csb2nvdla_ready(csb_ready),
      .csb2nvdla_addr(csb_addr), .csb2nvdla_wdat(csb_wdat),
      .csb2nvdla_write(csb_write), .csb2nvdla_nposted(csb_nposted),
      .nvdla2csb_valid(nv_valid), .nvdla2csb_data(nv_data),
      .nvdla2csb_wr_complete(wr_cmp), .err_count(err_count));

   apb_csb_bridge_v2 #(.NPOSTED_WR(1'b0), .TIMEOUT_CYC(16)) u_post (
      .clk(clk), .reset(reset), .psel(psel), .penable(penable), .pwrite(pwrite),
      .paddr(paddr), .pwdata(pwdata), .prdata(p_prdata), .pready(p_pready),
      .pslverr(p_pslverr), .csb2nvdla_valid(p_valid), .csb2nvdla_ready(csb_ready),
      .csb2nvdla_addr(p_addr), .csb2nvdla_wdat(p_wdat),
      .csb2nvdla_write(p_write), .csb2nvdla_nposted(p_nposted),
      .nvdla2csb_valid(nv_valid), .nvdla2csb_data(nv_data),
      .nvdla2csb_wr_complete(wr_cmp), .err_count(p_err_count));

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   always @(posedge clk) cyc++;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- scoreboard ----------------
   typedef struct {
      logic [31:0] data;
      logic        err;
      int          start;
      int          lat;
   } exp_t;
   exp_t q[$];

   always @(negedge clk) begin
      exp_t e;
      if (!reset && pready) begin
         if (q.size() == 0) begin
            chk("unexpected_pready", 32'd1, 32'd0);
         end else begin
            e = q.pop_front();
            chk("prdata",  prdata, e.data);
            chk("pslverr", {31'b0, pslverr}, {31'b0, e.err});
            chk("latency", 32'(cyc - e.start), 32'(e.lat));
         end
      end
   end

   // posted instance completion record
   int   p_cyc = 0;
   logic p_err = 1'b0;
   always @(negedge clk) if (!reset && p_pready) begin p_cyc = cyc; p_err = p_pslverr; end

   // CSB valid occupancy and request stability
   int          vcnt = 0, stab_err = 0;
   logic        prev_v = 1'b0;
   logic [15:0] s_addr;
   logic [31:0] s_wdat;
   always @(negedge clk) begin
      if (csb_valid) begin
         vcnt++;
         if (prev_v && (csb_addr !== s_addr || csb_wdat !== s_wdat)) stab_err++;
         s_addr = csb_addr;
         s_wdat = csb_wdat;
      end
      prev_v = csb_valid;
   end

   // ---------------- CSB responder ----------------
   int          rdy_dly = 0, rsp_dly = 0, wcnt = 0, rsp_cyc = 0;
   logic        rsp_en = 1'b1, rsp_pend = 1'b0, rsp_wr = 1'b0, inj = 1'b0;
   logic [31:0] rsp_data = '0, inj_data = '0;
   logic [15:0] hs_addr;
   logic [31:0] hs_wdat;
   logic        hs_write, hs_nposted, hs_p_nposted;

   initial begin
      csb_ready = 1'b0; nv_valid = 1'b0; wr_cmp = 1'b0; nv_data = '0;
      forever begin
         @(posedge clk); #1;
         csb_ready = 1'b0; nv_valid = 1'b0; wr_cmp = 1'b0;
         if (reset) begin
            wcnt = 0;
         end else if (csb_valid) begin
            if (wcnt == rdy_dly) begin
               csb_ready    = 1'b1;
               wcnt         = 0;
               hs_addr      = csb_addr;
               hs_wdat      = csb_wdat;
               hs_write     = csb_write;
               hs_nposted   = csb_nposted;
               hs_p_nposted = p_nposted;
               if (rsp_en) begin
                  rsp_pend = 1'b1;
                  rsp_cyc  = cyc + rsp_dly;
                  rsp_wr   = csb_write;
               end
            end else begin
               wcnt++;
            end
         end
         if (rsp_pend && cyc == rsp_cyc) begin
            rsp_pend = 1'b0;
            if (rsp_wr) wr_cmp = 1'b1;
            else begin nv_valid = 1'b1; nv_data = rsp_data; end
         end
         if (inj) begin
            inj = 1'b0; nv_valid = 1'b1; nv_data = inj_data;
         end
      end
   end

   // ---------------- APB driver ----------------
   int last_start = 0;

   task automatic apb(input logic wr, input logic [31:0] a, input logic [31:0] d,
                      input logic [31:0] ed, input logic ee, input int el);
      exp_t e;
      int   n;
      @(posedge clk); #1;
      psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
      @(posedge clk); #1;
      penable = 1'b1;
      e.data = ed; e.err = ee; e.start = cyc; e.lat = el;
      last_start = cyc;
      q.push_back(e);
      n = 0;
      do begin @(negedge clk); n++; end while (!pready && n < 300);
      chk("apb_done", {31'b0, pready}, 32'd1);
      if (!pready) q.delete();
      @(posedge clk); #1;
      psel = 1'b0; penable = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int v0;
      reset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
      repeat (3) @(negedge clk);
      chk("rst_ctrl", {27'b0, pready, pslverr, csb_valid, csb_write, csb_nposted}, 32'd0);
      chk("rst_prdata", prdata, 32'd0);
      chk("rst_addr", {16'b0, csb_addr}, 32'd0);
      chk("rst_wdat", csb_wdat, 32'd0);
      chk("rst_errcnt", {16'b0, err_count}, 32'd0);
      @(posedge clk); #1 reset = 1'b0;

      // read, ready immediate, data 5 cycles after accept: 2 + 5
      rdy_dly = 0; rsp_dly = 5; rsp_en = 1'b1; rsp_data = 32'h1234_5678;
      apb(1'b0, 32'h0000_1004, 32'h0, 32'h1234_5678, 1'b0, 7);
      chk("rd_addr", {16'b0, hs_addr}, 32'h0401);
      chk("rd_dir", {30'b0, hs_write, hs_nposted}, 32'd0);

      // non-posted write, completion 3 cycles after accept: 2 + 3
      rsp_dly = 3;
      apb(1'b1, 32'h0000_0010, 32'hA5A5_A5A5, 32'h0, 1'b0, 5);
      chk("wr_addr", {16'b0, hs_addr}, 32'h0004);
      chk("wr_wdat", hs_wdat, 32'hA5A5_A5A5);
      chk("wr_nposted", {31'b0, hs_nposted}, 32'd1);
      // posted instance finishes the cycle after accept
      chk("post_nposted", {31'b0, hs_p_nposted}, 32'd0);
      chk("post_lat", 32'(p_cyc - last_start), 32'd2);
      chk("post_err", {31'b0, p_err}, 32'd0);

      // window errors: no CSB traffic, pready on the next cycle
      v0 = vcnt;
      apb(1'b0, 32'h0004_0000, 32'h0, 32'hDEAD_BEEF, 1'b1, 1);
      chk("win_no_csb", 32'(vcnt - v0), 32'd0);
      chk("win_errcnt1", {16'b0, err_count}, 32'd1);
      apb(1'b1, 32'h8000_0010, 32'h1, 32'h0, 1'b1, 1);
      chk("win_errcnt2", {16'b0, err_count}, 32'd2);

      // timeout: 16 waiting cycles after the accept cycle
      rsp_en = 1'b0;
      apb(1'b0, 32'h0000_2000, 32'h0, 32'hDEAD_BEEF, 1'b1, 18);
      chk("tmo_errcnt", {16'b0, err_count}, 32'd3);
      // late response is swallowed; next read gets its own data
      repeat (2) @(posedge clk);
      #1 inj_data = 32'h7777_7777; inj = 1'b1;
      rsp_en = 1'b1; rsp_dly = 2; rsp_data = 32'hCAFE_F00D;
      apb(1'b0, 32'h0000_2004, 32'h0, 32'hCAFE_F00D, 1'b0, 4);

      // timeout with no late response: next access held until the orphan
      // window (16 cycles from the timeout RESP cycle) ages out -> 13 extra
      rsp_en = 1'b0;
      apb(1'b0, 32'h0000_2008, 32'h0, 32'hDEAD_BEEF, 1'b1, 18);
      chk("tmo2_errcnt", {16'b0, err_count}, 32'd4);
      rsp_en = 1'b1; rsp_dly = 1; rsp_data = 32'h0BAD_CAFE;
      apb(1'b0, 32'h0000_200C, 32'h0, 32'h0BAD_CAFE, 1'b0, 16);

      // ready held low 50 cycles: request stable, no timeout in REQ
      rdy_dly = 50; rsp_dly = 1; v0 = vcnt; stab_err = 0;
      apb(1'b1, 32'h0000_0020, 32'h1111_2222, 32'h0, 1'b0, 53);
      chk("stall_stable", 32'(stab_err), 32'd0);
      chk("stall_valid_cycles", 32'(vcnt - v0), 32'd51);
      chk("stall_wdat", hs_wdat, 32'h1111_2222);
      rdy_dly = 0;

      // reset while waiting for read data
      rsp_en = 1'b0;
      @(posedge clk); #1 psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h0000_3000;
      @(posedge clk); #1 penable = 1'b1;
      repeat (4) @(posedge clk);
      #1 reset = 1'b1;
      #1;
      chk("mid_rst_ctrl", {29'b0, pready, pslverr, csb_valid}, 32'd0);
      chk("mid_rst_prdata", prdata, 32'd0);
      chk("mid_rst_errcnt", {16'b0, err_count}, 32'd0);
      @(posedge clk); #1 psel = 1'b0; penable = 1'b0;
      @(posedge clk); #1 reset = 1'b0;
      // stray response after reset must be ignored
      inj_data = 32'h9999_9999; inj = 1'b1;
      repeat (2) @(posedge clk);
      rsp_en = 1'b1; rsp_dly = 0; rsp_data = 32'h55AA_33CC;
      apb(1'b0, 32'h0000_3004, 32'h0, 32'h55AA_33CC, 1'b0, 2);
      chk("post_rst_errcnt", {16'b0, err_count}, 32'd0);

      repeat (5) @(posedge clk);
      chk("queue_drained", 32'(q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/apb_csb_bridge_v2.md
Name: apb_csb_bridge_v2

Overview:
Parametrised APB-slave to CSB-master bridge sitting between the PS APB port and the NVDLA core CSB interface. It converts each APB access into exactly one CSB request. Over the previous bridge it adds:
- selectable posted/non-posted writes;
- an address-window check that returns pslverr;
- a response timeout with pslverr;
- orphan-response discard;
- a saturating error counter.

Parameters:
- ADDR_W, 32, APB paddr width.
- CSB_ADDR_W, 16, CSB word-address width; csb2nvdla_addr = paddr[CSB_ADDR_W+1:2].
- DATA_W, 32, APB/CSB data width.
- WIN_BASE, 32'h0000_0000, byte base of accepted window; compared on paddr[ADDR_W-1:CSB_ADDR_W+2].
- NPOSTED_WR, 1, 1 = writes wait for nvdla2csb_wr_complete; 0 = writes complete on CSB accept.
- TIMEOUT_CYC, 1024, cycles allowed from CSB accept to response; 0 disables the timeout.
- ERR_DATA, 32'hDEAD_BEEF, prdata driven on read error.

Ports:
- clk  in  1  bridge clock, shared APB/CSB domain.
- reset  in  1  asynchronous active-high reset.
- psel  in  1  APB select.
- penable  in  1  APB enable (access phase).
- pwrite  in  1  APB direction, 1 = write.
- paddr  in  ADDR_W  APB byte address.
- pwdata  in  DATA_W  APB write data.
- prdata  out  DATA_W  APB read data.
- pready  out  1  APB ready.
- pslverr  out  1  APB error, valid only with pready.
- csb2nvdla_valid  out  1  CSB request valid.
- csb2nvdla_ready  in  1  CSB request accept.
- csb2nvdla_addr  out  CSB_ADDR_W  CSB word address.
- csb2nvdla_wdat  out  DATA_W  CSB write data.
- csb2nvdla_write  out  1  CSB direction.
- csb2nvdla_nposted  out  1  equals NPOSTED_WR on writes, 0 on reads.
- nvdla2csb_valid  in  1  read data return.
- nvdla2csb_data  in  DATA_W  read data.
- nvdla2csb_wr_complete  in  1  non-posted write completion.
- err_count  out  16  saturating count of window errors and timeouts.

Behaviour:
Interface:
- One clock, clk.
- reset is asynchronous, active-high.
- All flops clear on reset assertion; reset is released synchronously by the integrator.

Reset values:
- prdata=0, pready=0, pslverr=0.
- csb2nvdla_valid=0, csb2nvdla_addr=0, csb2nvdla_wdat=0, csb2nvdla_write=0, csb2nvdla_nposted=0.
- err_count=0, orphan=0, FSM in IDLE.

FSM:
- IDLE: on psel&penable, latch addr/data/dir.
  - Out of window: go to RESP with err=1; no CSB traffic.
  - In window: go to REQ.
- REQ: csb2nvdla_valid=1 and fields held stable until csb2nvdla_ready. On handshake:
  - read: go to WAIT_RD;
  - write with NPOSTED_WR=1: go to WAIT_WR;
  - write with NPOSTED_WR=0: go to RESP, err=0.
  - REQ has no timeout.
- WAIT_RD: on nvdla2csb_valid, capture data and go to RESP. Same-cycle acceptance is allowed: if nvdla2csb_valid arrives in the REQ handshake cycle, it is captured.
- WAIT_WR: on nvdla2csb_wr_complete, go to RESP.
- Timeout in WAIT_RD/WAIT_WR:
  - a counter starts at 0 on CSB accept;
  - when it reaches TIMEOUT_CYC-1 with no response: go to RESP, err=1, prdata=ERR_DATA (reads), set orphan=1.
- RESP: pready=1 and pslverr=err for exactly one cycle, then IDLE.
  - prdata holds captured data on read success, ERR_DATA on read error, 0 on writes.

Orphan handling:
- While orphan=1, the next nvdla2csb_valid or nvdla2csb_wr_complete is consumed silently and clears orphan.
- A new APB access is held in IDLE (pready=0) until orphan clears, or for TIMEOUT_CYC further cycles, after which orphan is force-cleared.
- A response arriving while not expected and orphan=0 is ignored.

Other rules:
- err_count increments by 1 per window error or timeout, saturating at 16'hFFFF.
- Latency from APB access phase to pready:
  - window error: 2 cycles;
  - posted write with ready=1: 3 cycles;
  - read: 3 + CSB response delay.
- psel dropping mid-transaction is a protocol violation; the bridge still completes the CSB transaction.
- Reset mid-transaction aborts all state with no CSB retry; any later response is ignored as unexpected.

Decomposition:
- Shared package apb_csb_pkg holds:
  - FSM state enum (IDLE, REQ, WAIT_RD, WAIT_WR, RESP);
  - default ERR_DATA;
  - the window-match function.
- One sub-module: csb_resp_timer, the loadable timeout counter with expire pulse and disable-when-0 behaviour.

Test Plan:
- Read 0x0000_1004, CSB ready immediate, data 0x1234_5678 after 5 cycles -> csb2nvdla_addr=0x0401, write=0, nposted=0; prdata=0x1234_5678, pready=1, pslverr=0.
- Write 0x0000_0010 data 0xA5A5_A5A5, NPOSTED_WR=1, wr_complete after 3 cycles -> addr=0x0004, nposted=1; pready only after wr_complete, pslverr=0. Same write with NPOSTED_WR=0 -> pready on the cycle after accept.
- Access 0x0004_0000 with WIN_BASE=0 -> no csb2nvdla_valid; pready with pslverr=1 after 2 cycles; err_count=1.
- TIMEOUT_CYC=16, read with no response -> pready with pslverr=1, prdata=0xDEAD_BEEF after 16 cycles. A late nvdla2csb_valid is dropped, and the next read returns its own data.
- csb2nvdla_ready held low 50 cycles -> valid/addr/wdat stable throughout; no timeout.
- Assert reset while in WAIT_RD -> all outputs at reset values immediately; a subsequent read completes normally; err_count=0.
